// File: rtl/uart_tx_fifo_if.sv
// Byte intake handshake between a host-side producer and the UART transmitter.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small valid/ready intake FIFO and a frame-aligned baud counter.
module uart_tx_fifo #(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_fifo_if.slave               in_if,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CPB    = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned BAUD_W = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BIT_W  = 4;
  localparam logic        ODD_PAR = (PARITY == 1);

  // Reject unsupported configurations at elaboration time.
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || CPB < 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] head_c;
  logic                 push_c, pop_c, last_tick_c;

  assign head_c      = mem_q[rd_ptr_q];
  assign last_tick_c = (baud_q == BAUD_W'(CPB - 1));

  // Frame sequencing: decides next state, line level and when to pop the FIFO head.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        pop_c = (count_q != '0);
      end
      S_START: begin
        if (last_tick_c) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (last_tick_c) begin
          baud_d = '0;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_PARITY: begin
        if (last_tick_c) begin
          state_d = S_STOP;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (last_tick_c) begin
          baud_d = '0;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (count_q != '0) begin
              pop_c = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Popping always launches a new frame; parity is fixed from the word as popped.
    if (pop_c) begin
      shift_d = head_c;
      par_d   = (^head_c) ^ ODD_PAR;
      state_d = S_START;
      baud_d  = '0;
      bit_d   = '0;
      tx_d    = 1'b0;
    end
  end

  // FIFO pointers, occupancy and the registered ready/busy flags.
  always_comb begin
    push_c   = in_if.valid && ready_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    busy_d  = (state_d != S_IDLE) || (count_d != '0);
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= in_if.data;
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign fifo_count  = count_q;
  assign in_if.ready = ready_q;

endmodule
